fetch_unit: RTL

The fetch unit owns the PC, the instruction-memory request port and the IF/ID pipeline register. It obeys the hold signals produced by hazard detection and the branch/jump flush from ID. It absorbs a variable-latency instruction memory through a req/ack handshake, inserting bubbles into IF/ID whenever no instruction is ready. It sits between the instruction memory and the ID stage of the 5-stage CPU and replaces the bare PC register plus IF/ID register.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared types and constants for the 5-stage CPU front end.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_BUF  = 2'd2,
        FETCH_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : PC, instruction-memory req/ack port and IF/ID register with
//            hold, flush and bubble insertion for a variable-latency memory.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        WritePC_i,
    input  logic        WriteIFID_i,
    input  logic        Flush_i,
    input  logic [31:0] Target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] PC_o,
    output logic [31:0] IFID_PC4_o,
    output logic [31:0] IFID_Inst_o,
    output logic        IFID_Valid_o
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_drop_addr;
    logic [63:0] r_buf;
    logic [31:0] r_ifid_pc4;
    logic [31:0] r_ifid_inst;
    logic        r_ifid_valid;

    logic        w_hold;
    logic        w_flush;
    logic [31:0] w_pc_plus4;

    assign w_hold     = ~WritePC_i | ~WriteIFID_i;
    assign w_flush    = Flush_i & (r_state != FETCH_IDLE);
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_flush) begin
            // An outstanding request without its ack must be drained first.
            if ((r_state == FETCH_WAIT || r_state == FETCH_DROP) && !imem_ack_i) begin
                w_next_state = FETCH_DROP;
            end else begin
                w_next_state = FETCH_WAIT;
            end
        end else begin
            case (r_state)
                FETCH_IDLE: if (start_i) w_next_state = FETCH_WAIT;
                FETCH_WAIT: if (imem_ack_i && w_hold) w_next_state = FETCH_BUF;
                FETCH_BUF:  if (!w_hold) w_next_state = FETCH_WAIT;
                FETCH_DROP: if (imem_ack_i) w_next_state = FETCH_WAIT;
                default:    w_next_state = FETCH_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req_o  = (r_state == FETCH_WAIT) || (r_state == FETCH_DROP);
        // DROP keeps presenting the flushed address while PC already holds the target.
        imem_addr_o = (r_state == FETCH_DROP) ? r_drop_addr : r_pc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc         <= RESET_PC;
            r_drop_addr  <= RESET_PC;
            r_buf        <= 64'd0;
            r_ifid_pc4   <= 32'd0;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
        end else if (w_flush) begin
            r_pc         <= Target_i;
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
            if (r_state == FETCH_WAIT && !imem_ack_i) begin
                r_drop_addr <= r_pc;
            end
        end else begin
            case (r_state)
                FETCH_WAIT: begin
                    if (imem_ack_i && !w_hold) begin
                        r_ifid_pc4   <= w_pc_plus4;
                        r_ifid_inst  <= imem_data_i;
                        r_ifid_valid <= 1'b1;
                        r_pc         <= w_pc_plus4;
                    end else if (imem_ack_i) begin
                        r_buf <= {w_pc_plus4, imem_data_i};
                    end else if (!w_hold) begin
                        r_ifid_inst  <= NOP_INST;
                        r_ifid_valid <= 1'b0;
                    end
                end
                FETCH_BUF: begin
                    if (!w_hold) begin
                        r_ifid_pc4   <= r_buf[63:32];
                        r_ifid_inst  <= r_buf[31:0];
                        r_ifid_valid <= 1'b1;
                        r_pc         <= w_pc_plus4;
                    end
                end
                FETCH_DROP: begin
                    if (!w_hold) begin
                        r_ifid_inst  <= NOP_INST;
                        r_ifid_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign PC_o         = r_pc;
    assign IFID_PC4_o   = r_ifid_pc4;
    assign IFID_Inst_o  = r_ifid_inst;
    assign IFID_Valid_o = r_ifid_valid;

endmodule : fetch_unit
`default_nettype wire
